dac_interp: RTL and testbench

//  Linear-interpolating upsampler on the DAC output path; the transmit-side counterpart of the ADC averaging filter.

---
 rtl/dac_interp_pkg.sv | 28 ++
 rtl/dac_interp_buf.sv | 44 ++++
 rtl/dac_interp.sv | 124 ++++++++++++
 tb/tb_dac_interp.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dac_interp_pkg.sv
// Shared types and defaults for the DAC linear-interpolating upsampler.
// Holds the FSM state type, default widths and width helper functions.
package dac_interp_pkg;

  localparam int DI_N = 8;
  localparam int DI_L = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Interpolation factor R = 2^L
  function automatic int ratio(input int l);
    return 1 << l;
  endfunction

  // Signed width that holds s1 - s0
  function automatic int step_w(input int n);
    return n + 1;
  endfunction

  // Signed accumulator width; its MSB is always 0
  function automatic int acc_w(input int n, input int l);
    return n + l + 1;
  endfunction

endpackage

// File: rtl/dac_interp_buf.sv
// One-entry holding buffer between the sample source and the ramp datapath.
// Ports: in_data/in_valid/in_ready handshake, wrap (slot frees this cycle),
// consume (datapath takes the entry), buf_data/buf_full (entry contents).
module dac_interp_buf
  import dac_interp_pkg::*;
#(
  parameter int N = DI_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  input  logic         wrap,
  input  logic         consume,
  output logic         in_ready,
  output logic [N-1:0] buf_data,
  output logic         buf_full
);

  logic         r_full;
  logic [N-1:0] r_data;
  logic         w_accept;

  // A wrap cycle frees the slot, so a new sample can refill it at once
  assign in_ready = ~r_full | wrap;
  assign w_accept = in_valid & in_ready;
  assign buf_data = r_data;
  assign buf_full = r_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      if (w_accept) begin
        r_full <= 1'b1;
        r_data <= in_data;
      end else if (consume) begin
        r_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dac_interp.sv
// Linear-interpolating upsampler: emits 2^L ramped DAC codes per input sample.
// Ports: clk, reset (async active-low), tick, in_data/in_valid/in_ready,
// dac_data, underrun; underrun_cnt with DAC_INTERP_UNDERRUN_CNT_EN defined.
module dac_interp
  import dac_interp_pkg::*;
#(
  parameter int N = DI_N,
  parameter int L = DI_L
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] dac_data,
`ifdef DAC_INTERP_UNDERRUN_CNT_EN
  output logic [15:0]  underrun_cnt,
`endif
  output logic         underrun
);

  localparam int R  = ratio(L);
  localparam int SW = step_w(N);
  localparam int AW = acc_w(N, L);
  localparam logic [L-1:0] PH_LAST = L'(R - 1);

  state_e                r_state;
  logic [L-1:0]          r_ph;
  logic [N-1:0]          r_s1;
  logic signed [SW-1:0]  r_step;
  logic signed [AW-1:0]  r_acc;
  logic                  r_underrun;

  logic                  w_wrap;
  logic                  w_start;
  logic                  w_consume;
  logic                  w_full;
  logic [N-1:0]          w_buf;
  logic signed [AW-1:0]  w_s1_acc;
  logic signed [AW-1:0]  w_buf_acc;
  logic signed [AW-1:0]  w_step_ext;
  logic signed [SW-1:0]  w_step_new;

  assign w_wrap    = tick & (r_state == RUN) & (r_ph == PH_LAST);
  assign w_start   = tick & (r_state == IDLE) & w_full;
  assign w_consume = w_start | (w_wrap & w_full);

  dac_interp_buf #(.N(N)) u_buf (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .wrap     (w_wrap),
    .consume  (w_consume),
    .in_ready (in_ready),
    .buf_data (w_buf),
    .buf_full (w_full)
  );

  // Segment start points sit at value*R in the accumulator
  assign w_s1_acc   = {1'b0, r_s1, {L{1'b0}}};
  assign w_buf_acc  = {1'b0, w_buf, {L{1'b0}}};
  assign w_step_new = {1'b0, w_buf} - {1'b0, r_s1};
  assign w_step_ext = {{L{r_step[SW-1]}}, r_step};

  assign dac_data = r_acc[N+L-1:L];
  assign underrun = r_underrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ph       <= '0;
      r_s1       <= '0;
      r_step     <= '0;
      r_acc      <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      unique case (1'b1)
        w_start: begin
          r_state <= RUN;
          r_s1    <= w_buf;
          r_acc   <= w_buf_acc;
          r_step  <= '0;
          r_ph    <= '0;
        end
        w_wrap & w_full: begin
          r_s1   <= w_buf;
          r_acc  <= w_s1_acc;
          r_step <= w_step_new;
          r_ph   <= '0;
        end
        w_wrap & ~w_full: begin
          // Starved: hold the last endpoint for a whole segment
          r_acc      <= w_s1_acc;
          r_step     <= '0;
          r_ph       <= '0;
          r_underrun <= 1'b1;
        end
        tick & (r_state == RUN) & ~w_wrap: begin
          r_acc <= r_acc + w_step_ext;
          r_ph  <= r_ph + L'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef DAC_INTERP_UNDERRUN_CNT_EN
  logic [15:0] r_ucnt;

  assign underrun_cnt = r_ucnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ucnt <= '0;
    end else if (w_wrap & ~w_full & (r_ucnt != 16'hFFFF)) begin
      r_ucnt <= r_ucnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_interp.sv
// Self-checking bench for dac_interp (N=8, L=2).
// Segment-level reference model plus literal ramp expectations.
module tb_dac_interp;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dac_data;
  logic       underrun;
`ifdef DAC_INTERP_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  dac_interp #(.N(8), .L(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dac_data     (dac_data),
`ifdef DAC_INTERP_UNDERRUN_CNT_EN
    .underrun_cnt (underrun_cnt),
`endif
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: current segment (s0 -> s1), tick index k, buffer
  bit m_run, m_full, m_under;
  int m_k, m_s0, m_s1, m_buf, m_cnt;

  int feed[$];
  int dq[$];
  int uq[$];
  int exp_q[$];
  int n_acc;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_dac();
    int d, q;
    d = m_k * (m_s1 - m_s0);
    if (d >= 0) q = d / R;
    else q = -((-d + R - 1) / R);
    return m_s0 + q;
  endfunction

  task automatic model_reset();
    m_run = 0; m_full = 0; m_under = 0;
    m_k = 0; m_s0 = 0; m_s1 = 0; m_buf = 0; m_cnt = 0;
  endtask

  // Called at a negedge; returns whether the sample was accepted
  task automatic step(input bit t, input bit v, input int d,
                      output bit acc);
    bit rdy, cons;
    tick = t; in_valid = v; in_data = d[7:0];
    #1;
    rdy = !m_full || (t && m_run && m_k == R - 1);
    chk("in_ready", int'(in_ready), int'(rdy));
    acc = v && rdy;
    cons = 0;
    m_under = 0;
    if (t) begin
      if (!m_run) begin
        if (m_full) begin
          m_s0 = m_buf; m_s1 = m_buf; m_k = 0; m_run = 1; cons = 1;
        end
      end else if (m_k != R - 1) begin
        m_k++;
      end else begin
        m_s0 = m_s1; m_k = 0;
        if (m_full) begin
          m_s1 = m_buf; cons = 1;
        end else begin
          m_under = 1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
    end
    if (acc) begin
      m_full = 1; m_buf = d & 8'hFF;
    end else if (cons) begin
      m_full = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("dac_data", int'(dac_data), exp_dac());
    chk("underrun", int'(underrun), int'(m_under));
`ifdef DAC_INTERP_UNDERRUN_CNT_EN
    chk("underrun_cnt", int'(underrun_cnt), m_cnt);
`endif
  endtask

  // Asserted at a negedge: outputs must clear immediately
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_dac", int'(dac_data), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_underrun", int'(underrun), 0);
`ifdef DAC_INTERP_UNDERRUN_CNT_EN
    chk("rst_cnt", int'(underrun_cnt), 0);
`endif
    model_reset();
    tick = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_dir(input int period, input int nclk);
    bit a, t, v;
    int d;
    dq.delete(); uq.delete(); n_acc = 0;
    for (int c = 0; c < nclk; c++) begin
      t = ((c % period) == period - 1);
      v = feed.size() > 0;
      d = v ? feed[0] : int'($urandom_range(255));
      step(t, v, d, a);
      if (a) begin
        void'(feed.pop_front());
        n_acc++;
      end
      if (t && m_run) begin
        dq.push_back(int'(dac_data));
        uq.push_back(int'(underrun));
      end
    end
  endtask

  task automatic cmp_log(input string nm, input bit use_u);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (use_u) chk(nm, (i < uq.size()) ? uq[i] : -1, exp_q[i]);
      else chk(nm, (i < dq.size()) ? dq[i] : -1, exp_q[i]);
    end
  endtask

  initial begin
    bit a;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("init_dac", int'(dac_data), 0);
    chk("init_ready", int'(in_ready), 1);
    chk("init_underrun", int'(underrun), 0);
    reset = 1'b1;

    // Reset mid-ramp, then restart from IDLE
    feed = {50, 150, 250};
    run_dir(1, 8);
    do_reset();

    feed = {0, 100, 200};
    run_dir(1, 20);
    exp_q = {0, 0, 0, 0, 0, 25, 50, 75,
             100, 125, 150, 175, 200, 200, 200, 200, 200};
    cmp_log("ramp_up", 0);

    do_reset();
    feed = {200, 100};
    run_dir(1, 14);
    exp_q = {200, 200, 200, 200, 200, 175, 150, 125, 100};
    cmp_log("ramp_down", 0);

    do_reset();
    feed = {0, 3};
    run_dir(1, 14);
    exp_q = {0, 0, 0, 0, 0, 0, 1, 2, 3};
    cmp_log("floor", 0);

    do_reset();
    feed = {100};
    run_dir(1, 14);
    exp_q = {100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
    cmp_log("hold", 0);
    exp_q = {0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    cmp_log("underrun_pulse", 1);
`ifdef DAC_INTERP_UNDERRUN_CNT_EN
    chk("underrun_cnt_lit", int'(underrun_cnt), 3);
`endif

    // Slow tick, source always valid
    do_reset();
    feed.delete();
    for (int i = 0; i < 12; i++) feed.push_back(int'($urandom_range(255)));
    run_dir(3, 60);
    chk("slow_tick_accepts", n_acc, 6);

    // Randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(399) == 0) begin
        do_reset();
      end else begin
        step(bit'($urandom_range(1)), ($urandom_range(9) < 6),
             int'($urandom_range(255)), a);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
